dpram_fifo_ctrl: RTL

Synchronous FIFO controller that drives the team's 64x8 dual-port RAM (write through port A, read through port B) and exposes valid/ready stream interfaces on both sides. It sits directly upstream of the RAM and owns the pointers, the occupancy and the read-side prefetch, so producers and consumers never touch RAM addresses. The RAM output register is the FIFO output register: read data comes straight from RAM port B.

---
 rtl/dpram_fifo_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/dpram_fifo_ctrl.sv
// Stream FIFO controller for the 64x8 dual-port RAM: port A writes, port B prefetches the head.
// Optional macro FIFO_LEVEL_FLAGS_EN adds registered almost_full / almost_empty outputs.
module dpram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
`ifdef FIFO_LEVEL_FLAGS_EN
   ,
   parameter int AFULL_TH  = 56,
   parameter int AEMPTY_TH = 8
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [DATA_W-1:0] ram_data_a,
   output logic              ram_we_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_dout_b
`ifdef FIFO_LEVEL_FLAGS_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   // Handshake: a transfer happens on an edge where valid && ready; valid never waits on ready,
   // and a word offered with valid must stay put until it is taken.
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_q;
   logic              out_valid_q;

   logic              push;
   logic              pop;
   logic [ADDR_W:0]   push_w;
   logic [ADDR_W:0]   pop_w;
   logic [ADDR_W:0]   count_next;
   logic [ADDR_W:0]   remain;
   logic              out_valid_next;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign in_ready  = rst_n && !full;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid_q && out_ready;
   assign out_valid = out_valid_q;
   assign count     = count_q;

   assign push_w     = {{ADDR_W{1'b0}}, push};
   assign pop_w      = {{ADDR_W{1'b0}}, pop};
   assign count_next = count_q + push_w - pop_w;

   // Same-cycle pushes are left out: port B cannot see a word until the edge after its write.
   assign remain         = count_q - pop_w;
   assign out_valid_next = (remain != '0);

   assign ram_addr_a = wr_ptr;
   assign ram_data_a = in_data;
   assign ram_we_a   = push;
   assign ram_we_b   = 1'b0;

   // Point port B at the next head on a pop so back-to-back pops need no bubble.
   assign ram_addr_b = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
   assign out_data   = ram_dout_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count_q     <= count_next;
         out_valid_q <= out_valid_next;
      end
   end

`ifdef FIFO_LEVEL_FLAGS_EN
   // Level flags follow the occupancy the FIFO will hold after this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (32'(count_next) >= 32'(AFULL_TH));
         almost_empty <= (32'(count_next) <= 32'(AEMPTY_TH));
      end
   end
`endif

endmodule
